alu_issue: RTL and testbench



---
 rtl/alu_issue.sv | 133 +++++++++++++
 tb/tb_alu_issue.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/alu_issue.sv
// alu_issue: RV32I ID->EX issue stage; decodes ALU ops and queues them in a 2-entry skid buffer.
module alu_issue #(
  parameter int XLEN  = 32,
  parameter int CTR_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CTR_W-1:0] ctr,
  output logic [XLEN-1:0]  a,
  output logic [XLEN-1:0]  b,
  output logic [4:0]       rd,
  output logic             illegal
);
  typedef struct packed {
    logic [CTR_W-1:0] ctr;
    logic [XLEN-1:0]  a;
    logic [XLEN-1:0]  b;
    logic [4:0]       rd;
    logic             illegal;
  } op_t;
  op_t d, m, s;
  logic m_v, s_v, acc, drn;
  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [CTR_W-1:0] alu_f3;
  logic [XLEN-1:0] i_imm, s_imm, u_imm, shamt;
  assign opc   = instr[6:0];
  assign f3    = instr[14:12];
  assign f7    = instr[31:25];
  assign i_imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign s_imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
  assign u_imm = {instr[31:12], 12'b0};
  assign shamt = {{(XLEN-5){1'b0}}, instr[24:20]};
  always_comb begin
    case (f3)
      3'b000:  alu_f3 = 4'd0;
      3'b001:  alu_f3 = 4'd2;
      3'b010:  alu_f3 = 4'd3;
      3'b011:  alu_f3 = 4'd4;
      3'b100:  alu_f3 = 4'd5;
      3'b101:  alu_f3 = 4'd6;
      3'b110:  alu_f3 = 4'd8;
      default: alu_f3 = 4'd9;
    endcase
  end
  always_comb begin
    d = '0;
    d.rd = instr[11:7];
    case (opc)
      7'b0110011: begin
        d.a = rs1_data;
        d.b = rs2_data;
        d.ctr = f7 == 7'b0100000 ? (f3 == 3'b000 ? 4'd1 : 4'd7) : alu_f3;
        d.illegal = f7 == 7'b0100000 ? (f3 != 3'b000 && f3 != 3'b101) : f7 != 7'b0;
      end
      7'b0010011: begin
        d.a = rs1_data;
        d.b = f3[1:0] == 2'b01 ? shamt : i_imm;
        d.ctr = (f3 == 3'b101 && f7 == 7'b0100000) ? 4'd7 : alu_f3;
        d.illegal = f3 == 3'b001 ? f7 != 7'b0
                  : (f3 == 3'b101 && f7 != 7'b0 && f7 != 7'b0100000);
      end
      7'b0110111: d.b = u_imm;
      7'b0010111: begin
        d.a = pc;
        d.b = u_imm;
      end
      7'b0000011: begin
        d.a = rs1_data;
        d.b = i_imm;
      end
      7'b0100011: begin
        d.a = rs1_data;
        d.b = s_imm;
        d.rd = 5'd0;
      end
      7'b1100011: begin
        d.a = rs1_data;
        d.b = rs2_data;
        d.rd = 5'd0;
        d.ctr = f3[2] ? (f3[1] ? 4'd4 : 4'd3) : 4'd1;
        d.illegal = f3[2:1] == 2'b01;
      end
      default: d.illegal = 1'b1;
    endcase
    if (d.illegal) begin
      d = '0;
      d.illegal = 1'b1;
    end
  end
  assign acc = in_valid & ~s_v;
  assign drn = m_v & out_ready;
  // S only fills while M is stalled, so in_ready is simply the registered ~S.valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_v <= 1'b0;
      s_v <= 1'b0;
      m <= '0;
      s <= '0;
    end else if (flush) begin
      m_v <= 1'b0;
      s_v <= 1'b0;
    end else if (drn && s_v) begin
      m <= s;
      s_v <= 1'b0;
    end else if (drn) begin
      m_v <= acc;
      if (acc) m <= d;
    end else if (acc && !m_v) begin
      m <= d;
      m_v <= 1'b1;
    end else if (acc) begin
      s <= d;
      s_v <= 1'b1;
    end
  end
  assign in_ready  = ~s_v;
  assign out_valid = m_v;
  assign ctr       = m.ctr;
  assign a         = m.a;
  assign b         = m.b;
  assign rd        = m.rd;
  assign illegal   = m.illegal;
endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed decode vectors, skid/flush sequences and a randomized scoreboard run.
module tb_alu_issue;
  logic clk = 1'b0, rst, flush, in_valid, in_ready, out_valid, out_ready, illegal;
  logic [31:0] instr, pc, rs1_data, rs2_data, a, b;
  logic [3:0] ctr;
  logic [4:0] rd;
  int errors = 0, checks = 0;

  alu_issue dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .out_valid(out_valid), .out_ready(out_ready), .ctr(ctr), .a(a), .b(b),
    .rd(rd), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr, pc, rs1, rs2;
    logic [3:0]  ctr;
    logic [31:0] a, b;
    logic [4:0]  rd;
    logic        ill;
  } vec_t;

  typedef struct {
    logic [31:0] a, b;
  } exp_t;

  vec_t vecs[15];
  exp_t q[$];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] i, input logic [31:0] p, input logic [31:0] r1, input logic [31:0] r2);
    in_valid = 1'b1;
    instr = i;
    pc = p;
    rs1_data = r1;
    rs2_data = r2;
  endtask

  initial begin
    logic stall;
    logic [3:0] s_ctr;
    logic [31:0] s_a, s_b;
    logic [4:0] s_rd;
    logic s_ill;
    vecs[0]  = '{32'h002081B3, 32'h0,   32'h5,        32'h7, 4'd0, 32'h5,        32'h7,        5'd3, 1'b0};
    vecs[1]  = '{32'h40435293, 32'h0,   32'h80000000, 32'h9, 4'd7, 32'h80000000, 32'h4,        5'd5, 1'b0};
    vecs[2]  = '{32'h40031293, 32'h0,   32'h11,       32'h9, 4'd0, 32'h0,        32'h0,        5'd0, 1'b1};
    vecs[3]  = '{32'h0020E463, 32'h0,   32'h1,        32'h2, 4'd4, 32'h1,        32'h2,        5'd0, 1'b0};
    vecs[4]  = '{32'h12345217, 32'h100, 32'h55,       32'h9, 4'd0, 32'h100,      32'h12345000, 5'd4, 1'b0};
    vecs[5]  = '{32'hFFF00093, 32'h0,   32'h0,        32'h9, 4'd0, 32'h0,        32'hFFFFFFFF, 5'd1, 1'b0};
    vecs[6]  = '{32'h402081B3, 32'h0,   32'h20,       32'h8, 4'd1, 32'h20,       32'h8,        5'd3, 1'b0};
    vecs[7]  = '{32'hABCDE2B7, 32'h40,  32'h77,       32'h9, 4'd0, 32'h0,        32'hABCDE000, 5'd5, 1'b0};
    vecs[8]  = '{32'hFE20AE23, 32'h0,   32'h1000,     32'h3, 4'd0, 32'h1000,     32'hFFFFFFFC, 5'd0, 1'b0};
    vecs[9]  = '{32'hFF012383, 32'h0,   32'h2000,     32'h3, 4'd0, 32'h2000,     32'hFFFFFFF0, 5'd7, 1'b0};
    vecs[10] = '{32'h022081B3, 32'h0,   32'h5,        32'h7, 4'd0, 32'h0,        32'h0,        5'd0, 1'b1};
    vecs[11] = '{32'h0020A463, 32'h0,   32'h5,        32'h7, 4'd0, 32'h0,        32'h0,        5'd0, 1'b1};
    vecs[12] = '{32'h0000007F, 32'h0,   32'h5,        32'h7, 4'd0, 32'h0,        32'h0,        5'd0, 1'b1};
    vecs[13] = '{32'h01F35293, 32'h0,   32'hF0000000, 32'h7, 4'd6, 32'hF0000000, 32'h1F,       5'd5, 1'b0};
    vecs[14] = '{32'h0020E1B3, 32'h0,   32'hA,        32'h5, 4'd8, 32'hA,        32'h5,        5'd3, 1'b0};
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    instr = '0; pc = '0; rs1_data = '0; rs2_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    chk("rst out_valid", out_valid, 0);
    chk("rst in_ready", in_ready, 1);
    chk("rst ctr", ctr, 0);
    chk("rst a", a, 0);
    chk("rst b", b, 0);
    chk("rst rd", rd, 0);
    chk("rst illegal", illegal, 0);
    foreach (vecs[i]) begin
      drive(vecs[i].instr, vecs[i].pc, vecs[i].rs1, vecs[i].rs2);
      @(negedge clk) in_valid = 1'b0;
      chk($sformatf("v%0d out_valid", i), out_valid, 1);
      chk($sformatf("v%0d ctr", i), ctr, vecs[i].ctr);
      chk($sformatf("v%0d a", i), a, vecs[i].a);
      chk($sformatf("v%0d b", i), b, vecs[i].b);
      chk($sformatf("v%0d rd", i), rd, vecs[i].rd);
      chk($sformatf("v%0d illegal", i), illegal, vecs[i].ill);
    end
    @(negedge clk);
    chk("idle out_valid", out_valid, 0);
    // back-pressure: second op lands in the skid register
    out_ready = 1'b0;
    drive(32'hFFF00093, 0, 0, 0);
    @(negedge clk) drive(32'h00200113, 0, 0, 0);
    @(negedge clk) in_valid = 1'b0;
    chk("bp in_ready", in_ready, 0);
    chk("bp out_valid", out_valid, 1);
    chk("bp b first", b, 32'hFFFFFFFF);
    repeat (2) @(negedge clk);
    chk("bp hold b", b, 32'hFFFFFFFF);
    chk("bp hold rd", rd, 1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp drain b second", b, 2);
    chk("bp drain rd second", rd, 2);
    chk("bp drain out_valid", out_valid, 1);
    chk("bp drain in_ready", in_ready, 1);
    @(negedge clk);
    chk("bp empty out_valid", out_valid, 0);
    // flush with both entries full and a concurrent offer
    out_ready = 1'b0;
    drive(32'h002081B3, 0, 1, 1);
    @(negedge clk) drive(32'h002081B3, 0, 2, 2);
    @(negedge clk) begin
      drive(32'h002081B3, 0, 3, 3);
      flush = 1'b1;
    end
    @(negedge clk) begin
      flush = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
    end
    chk("flush out_valid", out_valid, 0);
    chk("flush in_ready", in_ready, 1);
    repeat (2) @(negedge clk);
    chk("flush no ghost", out_valid, 0);
    // randomized traffic against a FIFO scoreboard
    stall = 1'b0;
    s_ctr = '0; s_a = '0; s_b = '0; s_rd = '0; s_ill = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      chk("rnd out_valid", out_valid, q.size() > 0);
      chk("rnd in_ready", in_ready, q.size() < 2);
      if (stall) begin
        chk("rnd stable", {ctr, a, b, rd, illegal}, {s_ctr, s_a, s_b, s_rd, s_ill});
      end
      in_valid = $urandom_range(0, 1) == 1;
      out_ready = $urandom_range(0, 2) != 0;
      instr = {$urandom_range(0, 4095), 20'h00093};
      rs1_data = $urandom;
      rs2_data = $urandom;
      if (in_valid && in_ready) q.push_back('{rs1_data, {{20{instr[31]}}, instr[31:20]}});
      if (out_valid && out_ready) begin
        exp_t e;
        e = q.pop_front();
        chk("rnd a", a, e.a);
        chk("rnd b", b, e.b);
      end
      stall = out_valid && !out_ready;
      {s_ctr, s_a, s_b, s_rd, s_ill} = {ctr, a, b, rd, illegal};
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    while (q.size() > 0 && out_valid) begin
      exp_t e;
      e = q.pop_front();
      chk("tail b", b, e.b);
      @(negedge clk);
    end
    chk("tail queue empty", q.size(), 0);
    chk("tail out_valid", out_valid, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
